hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Consumes per-instruction D-stage use/def info (A1/Tuse1, A2/Tuse2, A3/Tnew, MDUreq) from the decoder.
//  Tracks destination/Tnew of instructions in E, M and W; produces F/D stall, E bubble and forwarding selects.
//  Holds an internal MDU busy countdown so MDU-touching instructions in D wait for mult/div completion.
//  Sits in the controller beside the D-stage decoder; drives the pipeline-register enables/clears and the forward muxes.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after mult/multu leaves E
//  DIV_CYCLES   10  busy cycles after div/divu leaves E
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  synchronous, active-high
//  D_A1,D_A2   in   5  D-stage source regs (0 = unused)
//  D_Tuse1/2   in   2  cycles from D until operand needed (0=D,1=E,2=M)
//  D_A3        in   5  D-stage dest reg (0 = none)
//  D_Tnew      in   2  cycles from D until result ready (1..3, 0 = none)
//  D_MDUreq    in   1  D instr reads/writes HI/LO or starts MDU
//  D_mdu_op    in   2  0 none/mf/mt, 1 mult(u), 2 div(u)
//  flush       in   1  exception/eret: clear E/M/W tracking
//  stall       out  1  hold PC and F/D register
//  clr_E       out  1  load bubble into D/E register
//  fwd_D1/2    out  2  D operand: 0 RF, 1 from E, 2 from M
//  fwd_E1/2    out  2  E operand: 0 pipe, 1 from M, 2 from W
//  fwd_M2      out  1  M store data: 0 pipe, 1 from W
//  mdu_busy    out  1  MDU countdown active
//  stall_cnt   out 32  stall cycles counted (see CONFIGURATION)
// BEHAVIOUR
//  Regs: E_{A1,A2,A3,Tnew,mdu_op}, M_{A2,A3,Tnew}, W_A3, mdu_cnt[3:0] (width to fit max param).
//  Reset/flush: all tracking regs 0; flush does NOT clear mdu_cnt (MDU keeps running). Outputs all 0 after reset.
//  Advance each cycle: E_Tnew <= sat0(D_Tnew-1); M_Tnew <= sat0(E_Tnew-1); W Tnew is always 0.
//  If stall: E regs <= 0 (bubble); M/W advance normally.
//  stall = data_stall | mdu_stall, combinational on current D/E/M state.
//  data_stall: for i in {1,2}: D_Ai!=0 & ((D_Ai==E_A3 & D_Tusei<E_Tnew) | (D_Ai==M_A3 & D_Tusei<M_Tnew)).
//  mdu_stall: D_MDUreq & (mdu_cnt!=0 | E_mdu_op!=0).
//  clr_E = stall. Stalled D instr re-evaluates every cycle; no deadlock (Tnew strictly decreases).
//  Forwarding, nearest stage wins, never from A==0:
//   fwd_D: E if E_A3==D_Ai & E_Tnew==0; else M if M_A3==D_Ai & M_Tnew==0; else 0.
//   fwd_E: M if M_A3==E_Ai & M_Tnew==0; else W if W_A3==E_Ai; else 0.
//   fwd_M2: W if W_A3==M_A2 & M_A2!=0.
//  MDU: when E_mdu_op!=0, mdu_cnt <= MULT_CYCLES or DIV_CYCLES at the edge; else decrement if !=0.
//   mdu_busy = (mdu_cnt!=0). New start while busy cannot occur (D stalls it).
//  reset mid-countdown: mdu_cnt<=0 immediately.
// CONFIGURATION
//  HAZARD_STALL_CNT_EN defined: stall_cnt increments (wraps at 2^32) every cycle stall=1; cleared by reset only.
//  Not defined: stall_cnt tied to 32'd0, no counter flops.
// TESTING
//  lw $1 then addu $2,$1,$3 (Tuse1=1): one cycle stall=1,clr_E=1; next cycle fwd_E1=2 (from W).
//  addu $1 then beq $1,$0 (Tuse=0): one stall; then fwd_D1=2 (from M, M_Tnew=0).
//  lui $1 then beq $1: no stall, fwd_D1=1 (E_Tnew=0); lw $0 then use $0: no stall, fwd=0.
//  addu $1 then sw $1 (Tuse2=2): no stall; fwd_E2=1 from M; 'lw $1;sw $1': fwd_M2=1.
//  div then mflo: mflo stalls DIV_CYCLES+1=11 cycles; mdu_busy high 10 cycles; mult gives 6.
//  flush with lw in E: next cycle E/M/W clear, no stall; reset mid-div: mdu_busy=0 next cycle.
//  With HAZARD_STALL_CNT_EN: after div/mflo scenario stall_cnt==11; without, stall_cnt==0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble generation, forwarding selects and MDU busy tracking.
// Optional stall-cycle counter is compiled in with `define HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    input  logic [1:0]  D_Tuse1,
    input  logic [1:0]  D_Tuse2,
    input  logic [4:0]  D_A3,
    input  logic [1:0]  D_Tnew,
    input  logic        D_MDUreq,
    input  logic [1:0]  D_mdu_op,
    input  logic        flush,
    output logic        stall,
    output logic        clr_E,
    output logic [1:0]  fwd_D1,
    output logic [1:0]  fwd_D2,
    output logic [1:0]  fwd_E1,
    output logic [1:0]  fwd_E2,
    output logic        fwd_M2,
    output logic        mdu_busy,
    output logic [31:0] stall_cnt
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [4:0]       e_a1_q, e_a1_d, e_a2_q, e_a2_d, e_a3_q, e_a3_d;
    logic [1:0]       e_tnew_q, e_tnew_d, e_mdu_op_q, e_mdu_op_d;
    logic [4:0]       m_a2_q, m_a2_d, m_a3_q, m_a3_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [4:0]       w_a3_q, w_a3_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic             data_stall, mdu_stall;

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic operand_stall(input logic [4:0] a, input logic [1:0] tuse,
                                           input logic [4:0] ea3, input logic [1:0] etnew,
                                           input logic [4:0] ma3, input logic [1:0] mtnew);
        return (a != 5'd0) && (((a == ea3) && (tuse < etnew)) || ((a == ma3) && (tuse < mtnew)));
    endfunction

    // Nearer stage has priority; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] a,
                                           input logic [4:0] near_a3, input logic near_rdy,
                                           input logic [4:0] far_a3, input logic far_rdy);
        if (a == 5'd0)                      return 2'd0;
        else if (a == near_a3 && near_rdy) return 2'd1;
        else if (a == far_a3 && far_rdy)   return 2'd2;
        else                               return 2'd0;
    endfunction

    always_comb begin
        data_stall = operand_stall(D_A1, D_Tuse1, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q) ||
                     operand_stall(D_A2, D_Tuse2, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
        mdu_stall  = D_MDUreq && ((mdu_cnt_q != '0) || (e_mdu_op_q != 2'd0));
        stall      = data_stall || mdu_stall;
        clr_E      = stall;
        mdu_busy   = (mdu_cnt_q != '0);
        fwd_D1     = fwd_sel(D_A1, e_a3_q, e_tnew_q == 2'd0, m_a3_q, m_tnew_q == 2'd0);
        fwd_D2     = fwd_sel(D_A2, e_a3_q, e_tnew_q == 2'd0, m_a3_q, m_tnew_q == 2'd0);
        fwd_E1     = fwd_sel(e_a1_q, m_a3_q, m_tnew_q == 2'd0, w_a3_q, 1'b1);
        fwd_E2     = fwd_sel(e_a2_q, m_a3_q, m_tnew_q == 2'd0, w_a3_q, 1'b1);
        fwd_M2     = (m_a2_q != 5'd0) && (m_a2_q == w_a3_q);
    end

    // A stalled D instruction leaves a bubble in E while M and W keep draining.
    always_comb begin
        e_a1_d     = stall ? 5'd0 : D_A1;
        e_a2_d     = stall ? 5'd0 : D_A2;
        e_a3_d     = stall ? 5'd0 : D_A3;
        e_tnew_d   = stall ? 2'd0 : dec_sat(D_Tnew);
        e_mdu_op_d = stall ? 2'd0 : D_mdu_op;
        m_a2_d     = e_a2_q;
        m_a3_d     = e_a3_q;
        m_tnew_d   = dec_sat(e_tnew_q);
        w_a3_d     = m_a3_q;
        if (flush) begin
            e_a1_d     = 5'd0;
            e_a2_d     = 5'd0;
            e_a3_d     = 5'd0;
            e_tnew_d   = 2'd0;
            e_mdu_op_d = 2'd0;
            m_a2_d     = 5'd0;
            m_a3_d     = 5'd0;
            m_tnew_d   = 2'd0;
            w_a3_d     = 5'd0;
        end
    end

    // The MDU keeps running across a flush, so the countdown ignores it.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (e_mdu_op_q == 2'd1)      mdu_cnt_d = CNT_W'(MULT_CYCLES);
        else if (e_mdu_op_q != 2'd0) mdu_cnt_d = CNT_W'(DIV_CYCLES);
        else if (mdu_cnt_q != '0)    mdu_cnt_d = mdu_cnt_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_a1_q     <= 5'd0;
            e_a2_q     <= 5'd0;
            e_a3_q     <= 5'd0;
            e_tnew_q   <= 2'd0;
            e_mdu_op_q <= 2'd0;
            m_a2_q     <= 5'd0;
            m_a3_q     <= 5'd0;
            m_tnew_q   <= 2'd0;
            w_a3_q     <= 5'd0;
            mdu_cnt_q  <= '0;
        end else begin
            e_a1_q     <= e_a1_d;
            e_a2_q     <= e_a2_d;
            e_a3_q     <= e_a3_d;
            e_tnew_q   <= e_tnew_d;
            e_mdu_op_q <= e_mdu_op_d;
            m_a2_q     <= m_a2_d;
            m_a3_q     <= m_a3_d;
            m_tnew_q   <= m_tnew_d;
            w_a3_q     <= w_a3_d;
            mdu_cnt_q  <= mdu_cnt_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= 32'd0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
